// File: rtl/fifo_serializer.sv
// Splits each in_width word from a depth-1 upstream FIFO into R = in_width/out_width beats, LSB slice first.
// First beat is registered one cycle after IN_DEQ; OUT_READY low holds the beat and blocks the next dequeue.
module fifo_serializer #(
  parameter int in_width  = 32,
  parameter int out_width = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [in_width-1:0]  IN_DATA,
  input  logic                 IN_EMPTY_N,
  output logic                 IN_DEQ,
  output logic [out_width-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 BUSY
);

  localparam int R  = in_width / out_width;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [in_width-1:0] shift_reg;
  logic                out_valid_q;
  logic [out_width-1:0] out_data_q;
  logic                last_beat;

  // The register keeps only the slices not yet presented; OUT_DATA holds the current one.
  assign last_beat = (state == SHIFT) && (cnt == LAST);

  assign IN_DEQ = IN_EMPTY_N & ~CLR & ~RST &
                  ((state == IDLE) | (last_beat & OUT_READY));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_reg   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (CLR) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (IN_DEQ) begin
      state       <= SHIFT;
      cnt         <= '0;
      shift_reg   <= IN_DATA >> out_width;
      out_data_q  <= IN_DATA[out_width-1:0];
      out_valid_q <= 1'b1;
    end else if ((state == SHIFT) && OUT_READY) begin
      if (!last_beat) begin
        cnt        <= cnt + CW'(1);
        shift_reg  <= shift_reg >> out_width;
        out_data_q <= shift_reg[out_width-1:0];
      end else begin
        state       <= IDLE;
        cnt         <= '0;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = out_valid_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: directed vector table, reset-mid-word sequence and random traffic vs. a beat-count model.
module tb_fifo_serializer;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic          CLK;
  logic          RST;
  logic          CLR;
  logic [IW-1:0] IN_DATA;
  logic          IN_EMPTY_N;
  logic          IN_DEQ;
  logic [OW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_serializer #(.in_width(IW), .out_width(OW)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_DATA(IN_DATA), .IN_EMPTY_N(IN_EMPTY_N),
    .IN_DEQ(IN_DEQ), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rst, clr, en, rdy;
    logic [IW-1:0] data;
    logic          deq, vld, dchk;
    logic [OW-1:0] dat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic clr, input logic en, input logic rdy,
                     input logic [IW-1:0] data, input logic deq, input logic vld,
                     input logic dchk, input logic [OW-1:0] dat);
    vec_t v;
    v.rst = rst; v.clr = clr; v.en = en; v.rdy = rdy; v.data = data;
    v.deq = deq; v.vld = vld; v.dchk = dchk; v.dat = dat;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic clr, input logic en, input logic rdy,
                       input logic [IW-1:0] data);
    RST = rst; CLR = clr; IN_EMPTY_N = en; OUT_READY = rdy; IN_DATA = data;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference model state: beats still owed from the current word.
  int            rem;
  logic [IW-1:0] cur_word;
  logic [IW-1:0] sb_q[$];
  logic [IW-1:0] asm_word;
  int            beat;

  initial begin
    drive(1, 0, 0, 1, '0);
    next_cycle();
    next_cycle();

    // Each row: inputs for one cycle, outputs expected before the next edge.
    // reset row, single word
    add(1,0,1,1,32'hA1B2C3D4, 0,0,1,8'h00);
    add(0,0,1,1,32'hA1B2C3D4, 1,0,1,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'hD4);
    add(0,0,0,1,32'h0,        0,1,1,8'hC3);
    add(0,0,0,1,32'h0,        0,1,1,8'hB2);
    add(0,0,0,1,32'h0,        0,1,1,8'hA1);
    add(0,0,0,1,32'h0,        0,0,0,8'h00);
    // stall three cycles on C3
    add(0,0,1,1,32'hA1B2C3D4, 1,0,0,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'hD4);
    add(0,0,1,0,32'h55667788, 0,1,1,8'hC3);
    add(0,0,1,0,32'h55667788, 0,1,1,8'hC3);
    add(0,0,1,0,32'h55667788, 0,1,1,8'hC3);
    add(0,0,0,1,32'h0,        0,1,1,8'hC3);
    add(0,0,0,1,32'h0,        0,1,1,8'hB2);
    add(0,0,0,1,32'h0,        0,1,1,8'hA1);
    add(0,0,0,1,32'h0,        0,0,0,8'h00);
    // flush after D4,C3
    add(0,0,1,1,32'hA1B2C3D4, 1,0,0,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'hD4);
    add(0,0,0,1,32'h0,        0,1,1,8'hC3);
    add(0,1,1,1,32'h99999999, 0,1,1,8'hB2);
    add(0,0,0,1,32'h0,        0,0,0,8'h00);
    add(0,0,1,1,32'h11223344, 1,0,0,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'h44);
    add(0,0,0,1,32'h0,        0,1,1,8'h33);
    add(0,0,0,1,32'h0,        0,1,1,8'h22);
    add(0,0,0,1,32'h0,        0,1,1,8'h11);
    add(0,0,0,1,32'h0,        0,0,0,8'h00);
    // back-to-back, second dequeue alongside beat 03
    add(0,0,1,1,32'h03020100, 1,0,0,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'h00);
    add(0,0,0,1,32'h0,        0,1,1,8'h01);
    add(0,0,0,1,32'h0,        0,1,1,8'h02);
    add(0,0,1,1,32'h07060504, 1,1,1,8'h03);
    add(0,0,0,1,32'h0,        0,1,1,8'h04);
    add(0,0,0,1,32'h0,        0,1,1,8'h05);
    add(0,0,0,1,32'h0,        0,1,1,8'h06);
    add(0,0,0,1,32'h0,        0,1,1,8'h07);
    add(0,0,0,1,32'h0,        0,0,0,8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].rdy, tbl[i].data);
      @(negedge CLK);
      check($sformatf("row%0d deq", i), {31'b0, IN_DEQ}, {31'b0, tbl[i].deq});
      check($sformatf("row%0d vld", i), {31'b0, OUT_VALID}, {31'b0, tbl[i].vld});
      check($sformatf("row%0d busy", i), {31'b0, BUSY}, {31'b0, tbl[i].vld});
      if (tbl[i].dchk)
        check($sformatf("row%0d data", i), {24'b0, OUT_DATA}, {24'b0, tbl[i].dat});
      next_cycle();
    end

    // Upstream empty for 10 cycles
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 32'hDEADBEEF);
      @(negedge CLK);
      check($sformatf("empty%0d deq", i), {31'b0, IN_DEQ}, 32'd0);
      check($sformatf("empty%0d vld", i), {31'b0, OUT_VALID}, 32'd0);
      next_cycle();
    end

    // Reset in the middle of a word
    drive(0, 0, 1, 1, 32'hCAFEF00D);
    next_cycle();
    drive(0, 0, 0, 1, '0);
    next_cycle();
    next_cycle();
    drive(1, 0, 1, 1, 32'h12345678);
    @(negedge CLK);
    check("rstmid deq", {31'b0, IN_DEQ}, 32'd0);
    check("rstmid vld_before", {31'b0, OUT_VALID}, 32'd1);
    check("rstmid data_before", {24'b0, OUT_DATA}, 32'h000000FE);
    next_cycle();
    drive(0, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("rstpost%0d vld", i), {31'b0, OUT_VALID}, 32'd0);
      check($sformatf("rstpost%0d busy", i), {31'b0, BUSY}, 32'd0);
      check($sformatf("rstpost%0d data", i), {24'b0, OUT_DATA}, 32'd0);
      next_cycle();
    end

    // Random traffic against the model
    drive(1, 0, 0, 1, '0);
    next_cycle();
    rem = 0; cur_word = '0; beat = 0; asm_word = '0;
    for (int c = 0; c < 3000; c++) begin
      logic en, rdy, exp_deq;
      if (c < 2900) begin
        en  = ($urandom_range(0, 99) < 70);
        rdy = ($urandom_range(0, 99) < 60);
      end else begin
        en = 1'b0; rdy = 1'b1;
      end
      drive(0, 0, en, rdy, $urandom);
      @(negedge CLK);
      exp_deq = en && ((rem == 0) || (rem == 1 && rdy));
      check("rnd deq", {31'b0, IN_DEQ}, {31'b0, exp_deq});
      if (IN_DEQ && !en) check("rnd deq_while_empty", 32'd1, 32'd0);
      check("rnd vld", {31'b0, OUT_VALID}, {31'b0, (rem > 0)});
      if (rem > 0)
        check("rnd data", {24'b0, OUT_DATA}, {24'b0, cur_word[(R - rem) * OW +: OW]});
      if (IN_DEQ) sb_q.push_back(IN_DATA);
      if (OUT_VALID && rdy) begin
        asm_word[beat * OW +: OW] = OUT_DATA;
        beat++;
        if (beat == R) begin
          beat = 0;
          if (sb_q.size() == 0) check("rnd sb_underflow", 32'd1, 32'd0);
          else check("rnd word", asm_word, sb_q.pop_front());
        end
      end
      if (rem > 0 && rdy) rem--;
      if (exp_deq) begin
        cur_word = IN_DATA;
        rem = R;
      end
      next_cycle();
    end
    check("rnd sb_leftover", sb_q.size(), 32'd0);
    check("rnd partial_beats", beat, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
